// File: rtl/ram_param_clr_if.sv
// ram_param_clr_if: access bus of the clearable RAM, master drives requests, slave returns read data and status.
interface ram_param_clr_if #(parameter int WIDTH = 16, parameter int ADDR_W = 14);
    logic [WIDTH-1:0]  in_i;
    logic [WIDTH-1:0]  out_o;
    logic [ADDR_W-1:0] sel_i;
    logic              load_i;
    logic              clr_i;
    logic              busy_o;
    logic              parity_err_o;
    modport master(output in_i, sel_i, load_i, clr_i, input out_o, busy_o, parity_err_o);
    modport slave(input in_i, sel_i, load_i, clr_i, output out_o, busy_o, parity_err_o);
endinterface

// File: rtl/ram_param_clr.sv
// ram_param_clr: single-port RAM, registered read, write-first, clear sweep after reset or on clr.
// Optional per-word even parity when RAM_PARITY_EN is defined.
module ram_param_clr #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input logic            clk,
    input logic            rst_n,
    ram_param_clr_if.slave bus
);
`ifdef RAM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              busy_q, perr_q, perr_d;
    logic [MW-1:0]     mem [DEPTH];
    logic [MW-1:0]     rdata, wdata;
    logic [ADDR_W-1:0] waddr;
    logic              in_range, we, clearing;
    assign clearing = state_q == CLEAR;
    assign in_range = {1'b0, bus.sel_i} < DEPTH_L;
    assign rdata    = mem[bus.sel_i];
    assign we       = clearing || (bus.load_i && in_range);
    assign waddr    = clearing ? ptr_q : bus.sel_i;
    assign out_d    = (clearing || !in_range) ? '0 : bus.load_i ? bus.in_i : rdata[WIDTH-1:0];
`ifdef RAM_PARITY_EN
    assign wdata  = clearing ? '0 : {^bus.in_i, bus.in_i};
    assign perr_d = !clearing && in_range && !bus.load_i && ((^rdata[WIDTH-1:0]) != rdata[WIDTH]);
`else
    assign wdata  = clearing ? '0 : bus.in_i;
    assign perr_d = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Sweep ends on the terminal compare; ptr is reloaded on the next clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            perr_q <= perr_d;
            if (clearing) begin
                ptr_q <= ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (bus.clr_i) begin
                state_q <= CLEAR;
                ptr_q   <= '0;
                busy_q  <= 1'b1;
            end
        end
    end
    assign bus.out_o        = out_q;
    assign bus.busy_o       = busy_q;
    assign bus.parity_err_o = perr_q;
endmodule
